// File: rtl/regfile_wb_queue.sv
// Writeback arbiter for the register file: ALU results (A) win, long-latency results (B) queue.
// Optional WB_QUEUE_BYPASS_EN lets B skip the queue when it is empty and A is idle.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_we,
    input  logic [4:0]    a_rd,
    input  logic [31:0]   a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [4:0]    b_rd,
    input  logic [31:0]   b_data,
    input  logic [4:0]    q_rs,
    input  logic [4:0]    q_rt,
    output logic          rs_pend,
    output logic          rt_pend,
    output logic          rf_w,
    output logic [4:0]    RdC,
    output logic [31:0]   Rd_in,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             rf_w_q, rf_w_d;
    logic [4:0]       rdc_q, rdc_d;
    logic [31:0]      rd_in_q, rd_in_d;

    logic             a_act, empty, pop, push_hs, push_en, bypass;
    logic [DEPTH-1:0] rs_hit, rt_hit;

    assign a_act   = a_we && (a_rd != 5'd0);
    assign empty   = (count_q == '0);
    assign b_ready = (count_q < FULL_CNT) && rst;
    assign push_hs = b_valid && b_ready;
    assign pop     = !a_act && !empty;

`ifdef WB_QUEUE_BYPASS_EN
    assign bypass  = empty && !a_act && push_hs && (b_rd != 5'd0);
`else
    assign bypass  = 1'b0;
`endif

    // Writes to r0 complete the handshake but never occupy a slot.
    assign push_en = push_hs && (b_rd != 5'd0) && !bypass;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic wr_sel, rd_sel, squash;
        assign wr_sel = push_en && (wr_ptr_q == AW'(gi));
        assign rd_sel = pop && (rd_ptr_q == AW'(gi));
        assign squash = a_act && (rd_q[gi] == a_rd);
        // The same-cycle push is younger than A, so it wins over the squash.
        assign live_d[gi] = wr_sel ? 1'b1 : (live_q[gi] && !squash && !rd_sel);
        assign rs_hit[gi] = live_q[gi] && (rd_q[gi] == q_rs);
        assign rt_hit[gi] = live_q[gi] && (rd_q[gi] == q_rt);
    end

    assign rs_pend = (q_rs != 5'd0) && (|rs_hit);
    assign rt_pend = (q_rt != 5'd0) && (|rt_hit);

    always_ff @(posedge clk) begin
        if (push_en) begin
            rd_q[wr_ptr_q]   <= b_rd;
            data_q[wr_ptr_q] <= b_data;
        end
    end

    always_comb begin
        rf_w_d  = 1'b0;
        rdc_d   = rdc_q;
        rd_in_d = rd_in_q;
        if (a_act) begin
            rf_w_d  = 1'b1;
            rdc_d   = a_rd;
            rd_in_d = a_data;
        end else if (pop) begin
            if (live_q[rd_ptr_q]) begin
                rf_w_d  = 1'b1;
                rdc_d   = rd_q[rd_ptr_q];
                rd_in_d = data_q[rd_ptr_q];
            end
        end else if (bypass) begin
            rf_w_d  = 1'b1;
            rdc_d   = b_rd;
            rd_in_d = b_data;
        end
    end

    always_comb begin
        wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rf_w_q   <= 1'b0;
            rdc_q    <= 5'd0;
            rd_in_q  <= 32'd0;
        end else begin
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rf_w_q   <= rf_w_d;
            rdc_q    <= rdc_d;
            rd_in_q  <= rd_in_d;
        end
    end

    assign rf_w  = rf_w_q;
    assign RdC   = rdc_q;
    assign Rd_in = rd_in_q;
    assign count = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_we = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_rd = 5'd0, b_rd = 5'd0, q_rs = 5'd0, q_rt = 5'd0;
    logic [31:0] a_data = 32'd0, b_data = 32'd0;
    logic        b_ready, rs_pend, rt_pend, rf_w;
    logic [4:0]  RdC;
    logic [31:0] Rd_in;
    logic [AW:0] count;

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .q_rs(q_rs), .q_rt(q_rt), .rs_pend(rs_pend), .rt_pend(rt_pend),
        .rf_w(rf_w), .RdC(RdC), .Rd_in(Rd_in), .count(count)
    );

    // Register file commits at the negedge inside the cycle the write is presented.
    logic [31:0] tb_rf [32];
    always @(negedge clk) if (rf_w) tb_rf[RdC] <= Rd_in;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } ent_t;

    ent_t        mq[$];
    logic        exp_w;
    logic [4:0]  exp_rdc;
    logic [31:0] exp_data;
    logic        exp_pre_ready, obs_pre_ready;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef WB_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic model_reset();
        mq.delete();
        exp_w = 1'b0; exp_rdc = 5'd0; exp_data = 32'd0;
    endtask

    task automatic model_tick(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                              input logic bv, input logic [4:0] br, input logic [31:0] bd);
        ent_t e;
        bit act, push, byp;
        act  = aw && (ar != 5'd0);
        push = bv && (mq.size() < DEPTH) && (br != 5'd0);
        byp  = BYP && (mq.size() == 0) && !act && push;
        exp_w = 1'b0;
        if (act) begin
            exp_w = 1'b1; exp_rdc = ar; exp_data = ad;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            if (e.live) begin exp_w = 1'b1; exp_rdc = e.rd; exp_data = e.data; end
        end else if (byp) begin
            exp_w = 1'b1; exp_rdc = br; exp_data = bd;
        end
        if (act) foreach (mq[i]) if (mq[i].rd == ar) mq[i].live = 1'b0;
        if (push && !byp) mq.push_back('{rd: br, data: bd, live: 1'b1});
    endtask

    function automatic logic model_pend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Drives one cycle of inputs, advances the model, returns at posedge+1.
    task automatic step(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic [4:0] qs, input logic [4:0] qt);
        a_we = aw; a_rd = ar; a_data = ad;
        b_valid = bv; b_rd = br; b_data = bd;
        q_rs = qs; q_rt = qt;
        #1;
        obs_pre_ready = b_ready;
        exp_pre_ready = (mq.size() < DEPTH);
        model_tick(aw, ar, ad, bv, br, bd);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_we = 1'($urandom); a_rd = 5'($urandom); a_data = $urandom;
            b_valid = 1'($urandom); b_rd = 5'($urandom); b_data = $urandom;
            @(negedge clk);
            n_cmp += 5;
            if (rf_w !== 1'b0) begin n_err++; $display("FAIL reset_rf_w got=%0b exp=0", rf_w); end
            if (RdC !== 5'd0) begin n_err++; $display("FAIL reset_RdC got=%0d exp=0", RdC); end
            if (Rd_in !== 32'd0) begin n_err++; $display("FAIL reset_Rd_in got=%h exp=0", Rd_in); end
            if (count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
            if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_ready got=%0b exp=0", b_ready); end
        end
        a_we = 1'b0; b_valid = 1'b0; a_rd = 5'd0; b_rd = 5'd0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (b_ready !== 1'b1) begin n_err++; $display("FAIL release_b_ready got=%0b exp=1", b_ready); end
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_a_only();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        n_cmp += 3;
        if (rf_w !== 1'b1) begin n_err++; $display("FAIL a_only_rf_w got=%0b exp=1", rf_w); end
        if (RdC !== 5'd5) begin n_err++; $display("FAIL a_only_RdC got=%0d exp=5", RdC); end
        if (Rd_in !== 32'hDEADBEEF) begin n_err++; $display("FAIL a_only_Rd_in got=%h exp=deadbeef", Rd_in); end
        @(negedge clk); #1;
        n_cmp++;
        if (tb_rf[5] !== 32'hDEADBEEF) begin n_err++; $display("FAIL a_only_rf5 got=%h exp=deadbeef", tb_rf[5]); end
        $display("test_a_only done");
    endtask

    task automatic test_b_fill();
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'd9, 32'h900 + 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0);
        n_cmp += 3;
        if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d exp=4", count); end
        if (b_ready !== 1'b0) begin n_err++; $display("FAIL fill_b_ready got=%0b exp=0", b_ready); end
        if (RdC !== 5'd9) begin n_err++; $display("FAIL fill_RdC got=%0d exp=9", RdC); end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            n_cmp += 3;
            if (rf_w !== 1'b1) begin n_err++; $display("FAIL drain%0d_rf_w got=%0b exp=1", i, rf_w); end
            if (RdC !== 5'(i)) begin n_err++; $display("FAIL drain%0d_RdC got=%0d exp=%0d", i, RdC, i); end
            if (Rd_in !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL drain%0d_Rd_in got=%h exp=%h", i, Rd_in, 32'h100 + 32'(i)); end
        end
        n_cmp++;
        if (count !== 3'd0) begin n_err++; $display("FAIL drain_count got=%0d exp=0", count); end
        $display("test_b_fill done");
    endtask

    task automatic test_squash();
        step(1'b1, 5'd9, 32'h11, 1'b1, 5'd7, 32'd1, 5'd7, 5'd0);
        n_cmp++;
        if (rs_pend !== 1'b1) begin n_err++; $display("FAIL squash_pend_before got=%0b exp=1", rs_pend); end
        step(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        n_cmp += 2;
        if (RdC !== 5'd7) begin n_err++; $display("FAIL squash_a_RdC got=%0d exp=7", RdC); end
        if (rs_pend !== 1'b0) begin n_err++; $display("FAIL squash_pend_after got=%0b exp=0", rs_pend); end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        n_cmp += 3;
        if (rf_w !== 1'b0) begin n_err++; $display("FAIL squash_pop_rf_w got=%0b exp=0", rf_w); end
        if (count !== 3'd0) begin n_err++; $display("FAIL squash_count got=%0d exp=0", count); end
        if (Rd_in !== 32'd2) begin n_err++; $display("FAIL squash_hold_Rd_in got=%h exp=2", Rd_in); end
        @(negedge clk); #1;
        n_cmp++;
        if (tb_rf[7] !== 32'd2) begin n_err++; $display("FAIL squash_rf7 got=%h exp=2", tb_rf[7]); end
        $display("test_squash done");
    endtask

    task automatic test_zero();
        step(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        n_cmp += 3;
        if (rf_w !== 1'b0) begin n_err++; $display("FAIL zero_rf_w got=%0b exp=0", rf_w); end
        if (count !== 3'd0) begin n_err++; $display("FAIL zero_count got=%0d exp=0", count); end
        if (rs_pend !== 1'b0) begin n_err++; $display("FAIL zero_rs_pend got=%0b exp=0", rs_pend); end
        $display("test_zero done");
    endtask

    task automatic test_bypass();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
`ifdef WB_QUEUE_BYPASS_EN
        n_cmp += 4;
        if (rf_w !== 1'b1) begin n_err++; $display("FAIL bypass_rf_w got=%0b exp=1", rf_w); end
        if (RdC !== 5'd3) begin n_err++; $display("FAIL bypass_RdC got=%0d exp=3", RdC); end
        if (Rd_in !== 32'h55) begin n_err++; $display("FAIL bypass_Rd_in got=%h exp=55", Rd_in); end
        if (count !== 3'd0) begin n_err++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
        n_cmp += 2;
        if (rf_w !== 1'b0) begin n_err++; $display("FAIL nobypass_rf_w got=%0b exp=0", rf_w); end
        if (count !== 3'd1) begin n_err++; $display("FAIL nobypass_count got=%0d exp=1", count); end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        n_cmp += 4;
        if (rf_w !== 1'b1) begin n_err++; $display("FAIL nobypass_rf_w2 got=%0b exp=1", rf_w); end
        if (RdC !== 5'd3) begin n_err++; $display("FAIL nobypass_RdC got=%0d exp=3", RdC); end
        if (Rd_in !== 32'h55) begin n_err++; $display("FAIL nobypass_Rd_in got=%h exp=55", Rd_in); end
        if (count !== 3'd0) begin n_err++; $display("FAIL nobypass_count2 got=%0d exp=0", count); end
`endif
        $display("test_bypass done");
    endtask

    task automatic test_random();
        logic aw, bv;
        logic [4:0] ar, br, qs, qt;
        logic [31:0] ad, bd;
        int errs0;
        errs0 = n_err;
        for (int c = 0; c < 400; c++) begin
            aw = ($urandom_range(0, 9) < 4);
            bv = ($urandom_range(0, 9) < 7);
            ar = 5'($urandom_range(0, 7));
            br = 5'($urandom_range(0, 7));
            qs = 5'($urandom_range(0, 7));
            qt = 5'($urandom_range(0, 7));
            ad = $urandom; bd = $urandom;
            step(aw, ar, ad, bv, br, bd, qs, qt);
            n_cmp += 7;
            if (obs_pre_ready !== exp_pre_ready) begin n_err++; $display("FAIL rnd%0d_b_ready got=%0b exp=%0b", c, obs_pre_ready, exp_pre_ready); end
            if (rf_w !== exp_w) begin n_err++; $display("FAIL rnd%0d_rf_w got=%0b exp=%0b", c, rf_w, exp_w); end
            if (RdC !== exp_rdc) begin n_err++; $display("FAIL rnd%0d_RdC got=%0d exp=%0d", c, RdC, exp_rdc); end
            if (Rd_in !== exp_data) begin n_err++; $display("FAIL rnd%0d_Rd_in got=%h exp=%h", c, Rd_in, exp_data); end
            if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd%0d_count got=%0d exp=%0d", c, count, mq.size()); end
            if (rs_pend !== model_pend(qs)) begin n_err++; $display("FAIL rnd%0d_rs_pend q=%0d got=%0b exp=%0b", c, qs, rs_pend, model_pend(qs)); end
            if (rt_pend !== model_pend(qt)) begin n_err++; $display("FAIL rnd%0d_rt_pend q=%0d got=%0b exp=%0b", c, qt, rt_pend, model_pend(qt)); end
        end
        $display("test_random done, %0d new errors", n_err - errs0);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 5'd9, 32'h1, 1'b1, 5'd5, 32'h50, 5'd5, 5'd0);
        step(1'b1, 5'd9, 32'h2, 1'b1, 5'd6, 32'h60, 5'd5, 5'd0);
        #2 rst = 1'b0;
        #1;
        n_cmp += 4;
        if (rf_w !== 1'b0) begin n_err++; $display("FAIL rstmid_rf_w got=%0b exp=0", rf_w); end
        if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        if (b_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_b_ready got=%0b exp=0", b_ready); end
        if (rs_pend !== 1'b0) begin n_err++; $display("FAIL rstmid_rs_pend got=%0b exp=0", rs_pend); end
        a_we = 1'b1; a_rd = 5'd5; a_data = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rf_w !== 1'b0) begin n_err++; $display("FAIL rstmid_hold%0d_rf_w got=%0b exp=0", i, rf_w); end
        end
        rst = 1'b1;
        model_reset();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        n_cmp += 2;
        if (rf_w !== 1'b0) begin n_err++; $display("FAIL rstmid_after_rf_w got=%0b exp=0", rf_w); end
        if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_after_count got=%0d exp=0", count); end
        $display("test_reset_mid done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_a_only();
        test_b_fill();
        test_squash();
        test_zero();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
